// File: rtl/phys_reg_free_list.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : phys_reg_free_list
// Purpose  : Free list of physical register indices shared by the two decode
//            lanes. Hands out up to two destination registers per cycle in
//            program order (lane 0 older) and takes back up to two registers
//            per cycle from retirement.
// Ports    : clk_i, rst_i                 - clock, sync active-high reset
//            alloc_req{0,1}_i             - lane wants a destination register
//            alloc_gnt{0,1}_o             - lane granted (combinational)
//            alloc_preg{0,1}_o            - register handed to the lane
//            free_vld{0,1}_i/free_preg*_i - register returned by retirement
//            count_o, empty_o             - registered occupancy
//            overflow_o                   - sticky: free arrived while full
// Revision : 1.0 - initial release
// ============================================================================
module phys_reg_free_list #(
    parameter int NUM_A_REGS = 32,
    parameter int NUM_P_REGS = 64,
    localparam int P_W   = $clog2(NUM_P_REGS),
    localparam int DEPTH = NUM_P_REGS - NUM_A_REGS,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_req0_i,
    input  logic             alloc_req1_i,
    output logic             alloc_gnt0_o,
    output logic             alloc_gnt1_o,
    output logic [P_W-1:0]   alloc_preg0_o,
    output logic [P_W-1:0]   alloc_preg1_o,
    input  logic             free_vld0_i,
    input  logic [P_W-1:0]   free_preg0_i,
    input  logic             free_vld1_i,
    input  logic [P_W-1:0]   free_preg1_i,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int                 c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_depth_ptr = (c_ptr_w + 1)'(DEPTH);
    localparam logic [CNT_W:0]     c_depth_cnt = (CNT_W + 1)'(DEPTH);

    logic [P_W-1:0]     r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_empty;
    logic               r_overflow;

    logic               w_have1;
    logic               w_have2;
    logic               w_gnt0;
    logic               w_gnt1;
    logic [1:0]         w_num_gnt;
    logic [c_ptr_w-1:0] w_head1;
    logic [CNT_W:0]     w_room0;
    logic [CNT_W:0]     w_room1;
    logic               w_acc0;
    logic               w_acc1;
    logic [1:0]         w_num_free;
    logic [c_ptr_w-1:0] w_wr1_ptr;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_ovf_evt;

    // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [c_ptr_w-1:0] ptr_add(input logic [c_ptr_w-1:0] ptr,
                                                   input logic [1:0]         inc);
        logic [c_ptr_w:0] sum;
        sum = {1'b0, ptr} + (c_ptr_w + 1)'(inc);
        if (sum >= c_depth_ptr) begin
            sum = sum - c_depth_ptr;
        end
        return sum[c_ptr_w-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Grants: decided only from the registered count, so a register freed
    // this cycle cannot be handed out until the next one. Lane 1 needs two
    // entries when lane 0 is also asking, which keeps grants in order.
    // ------------------------------------------------------------------
    always_comb begin
        w_have1   = (r_count != '0);
        w_have2   = (r_count > CNT_W'(1));
        w_gnt0    = ~rst_i & alloc_req0_i & w_have1;
        w_gnt1    = ~rst_i & alloc_req1_i & (alloc_req0_i ? w_have2 : w_have1);
        w_num_gnt = {1'b0, w_gnt0} + {1'b0, w_gnt1};
        w_head1   = ptr_add(r_head, 2'd1);
    end

    assign alloc_gnt0_o  = w_gnt0;
    assign alloc_gnt1_o  = w_gnt1;
    assign alloc_preg0_o = r_mem[r_head];
    assign alloc_preg1_o = alloc_req0_i ? r_mem[w_head1] : r_mem[r_head];

    // ------------------------------------------------------------------
    // Frees: room is measured after this cycle's grants, and lane 0 is
    // considered before lane 1 so a single slot goes to the older free.
    // ------------------------------------------------------------------
    always_comb begin
        w_room0     = {1'b0, r_count} - (CNT_W + 1)'(w_num_gnt);
        w_acc0      = free_vld0_i & (w_room0 < c_depth_cnt);
        w_room1     = w_room0 + (CNT_W + 1)'(w_acc0);
        w_acc1      = free_vld1_i & (w_room1 < c_depth_cnt);
        w_num_free  = {1'b0, w_acc0} + {1'b0, w_acc1};
        w_wr1_ptr   = w_acc0 ? ptr_add(r_tail, 2'd1) : r_tail;
        w_count_nxt = r_count - CNT_W'(w_num_gnt) + CNT_W'(w_num_free);
        w_ovf_evt   = (free_vld0_i & ~w_acc0) | (free_vld1_i & ~w_acc1);
    end

    // Storage: each entry reloads its identity mapping on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_mem[gi] <= P_W'(NUM_A_REGS + gi);
                end else if (w_acc0 && (r_tail == c_ptr_w'(gi))) begin
                    r_mem[gi] <= free_preg0_i;
                end else if (w_acc1 && (w_wr1_ptr == c_ptr_w'(gi))) begin
                    r_mem[gi] <= free_preg1_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= CNT_W'(DEPTH);
            r_empty    <= (DEPTH == 0);
            r_overflow <= 1'b0;
        end else begin
            r_head  <= ptr_add(r_head, w_num_gnt);
            r_tail  <= ptr_add(r_tail, w_num_free);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign count_o    = r_count;
    assign empty_o    = r_empty;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_phys_reg_free_list
// Purpose  : Self-checking bench for phys_reg_free_list. A queue of free
//            register numbers models the list; each driven cycle pushes its
//            expected outputs into a scoreboard that a negedge monitor pops.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_phys_reg_free_list;

    localparam int c_depth = 32;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       alloc_req0_i, alloc_req1_i;
    logic       alloc_gnt0_o, alloc_gnt1_o;
    logic [5:0] alloc_preg0_o, alloc_preg1_o;
    logic       free_vld0_i, free_vld1_i;
    logic [5:0] free_preg0_i, free_preg1_i;
    logic [5:0] count_o;
    logic       empty_o;
    logic       overflow_o;

    phys_reg_free_list #(.NUM_A_REGS(32), .NUM_P_REGS(64)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alloc_req0_i (alloc_req0_i),
        .alloc_req1_i (alloc_req1_i),
        .alloc_gnt0_o (alloc_gnt0_o),
        .alloc_gnt1_o (alloc_gnt1_o),
        .alloc_preg0_o(alloc_preg0_o),
        .alloc_preg1_o(alloc_preg1_o),
        .free_vld0_i  (free_vld0_i),
        .free_preg0_i (free_preg0_i),
        .free_vld1_i  (free_vld1_i),
        .free_preg1_i (free_preg1_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       gnt0;
        bit       gnt1;
        bit [5:0] p0;
        bit [5:0] p1;
        int       cnt;
        bit       ovf;
        bit       chk_state;
    } exp_t;

    exp_t sb[$];
    int   fl[$];          // reference free list, front = next to hand out
    bit   m_ovf   = 1'b0;
    bit   m_known = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Apply one cycle of inputs, record the expected outputs, advance the model.
    task automatic drive(input bit rst, input bit r0, input bit r1,
                         input bit v0, input logic [5:0] fp0,
                         input bit v1, input logic [5:0] fp1);
        exp_t e;
        int   avail;
        rst_i = rst; alloc_req0_i = r0; alloc_req1_i = r1;
        free_vld0_i = v0; free_preg0_i = fp0; free_vld1_i = v1; free_preg1_i = fp1;
        avail       = fl.size();
        e.chk_state = m_known;
        e.cnt       = avail;
        e.ovf       = m_ovf;
        e.gnt0      = !rst && r0 && (avail >= 1);
        e.gnt1      = !rst && r1 && (avail >= (r0 ? 2 : 1));
        e.p0        = (avail > 0) ? 6'(fl[0]) : 6'd0;
        e.p1        = r0 ? ((avail > 1) ? 6'(fl[1]) : 6'd0) : e.p0;
        sb.push_back(e);
        if (rst) begin
            fl.delete();
            for (int i = 0; i < c_depth; i++) fl.push_back(32 + i);
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (e.gnt0) void'(fl.pop_front());
            if (e.gnt1) void'(fl.pop_front());
            if (v0) begin
                if (fl.size() < c_depth) fl.push_back(int'(fp0)); else m_ovf = 1'b1;
            end
            if (v1) begin
                if (fl.size() < c_depth) fl.push_back(int'(fp1)); else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 6'd0, 0, 6'd0);
        tick();
    endtask

    task automatic alloc_pairs(input int n);
        repeat (n) begin
            drive(0, 1, 1, 0, 6'd0, 0, 6'd0);
            tick();
        end
    endtask

    // Reset, then leave exactly one entry (p63) in the list.
    task automatic goto_count1();
        do_reset();
        alloc_pairs(15);
        drive(0, 1, 0, 0, 6'd0, 0, 6'd0);
        tick();
        chk("count_at_one", 32'(count_o), 32'd1);
    endtask

    // Scoreboard monitor: one expected record per driven cycle.
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_gnt0", 32'(alloc_gnt0_o), 32'(e.gnt0));
            chk("sb_gnt1", 32'(alloc_gnt1_o), 32'(e.gnt1));
            if (e.gnt0) chk("sb_preg0", 32'(alloc_preg0_o), 32'(e.p0));
            if (e.gnt1) chk("sb_preg1", 32'(alloc_preg1_o), 32'(e.p1));
            if (e.chk_state) begin
                chk("sb_count", 32'(count_o), 32'(e.cnt));
                chk("sb_empty", 32'(empty_o), 32'(e.cnt == 0));
                chk("sb_overflow", 32'(overflow_o), 32'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int preq, pfree;
        rst_i = 1'b1; alloc_req0_i = 1'b0; alloc_req1_i = 1'b0;
        free_vld0_i = 1'b0; free_vld1_i = 1'b0; free_preg0_i = '0; free_preg1_i = '0;
        @(posedge clk_i); #1;

        // First dual allocation after reset.
        do_reset();
        chk("reset_count", 32'(count_o), 32'd32);
        chk("reset_empty", 32'(empty_o), 32'd0);
        chk("reset_overflow", 32'(overflow_o), 32'd0);
        drive(0, 1, 1, 0, 6'd0, 0, 6'd0);
        #2;
        chk("first_gnt0", 32'(alloc_gnt0_o), 32'd1);
        chk("first_gnt1", 32'(alloc_gnt1_o), 32'd1);
        chk("first_preg0", 32'(alloc_preg0_o), 32'd32);
        chk("first_preg1", 32'(alloc_preg1_o), 32'd33);
        tick();
        chk("count_after_first", 32'(count_o), 32'd30);

        // Drain to empty, then a denied dual request.
        alloc_pairs(15);
        chk("drained_count", 32'(count_o), 32'd0);
        chk("drained_empty", 32'(empty_o), 32'd1);
        drive(0, 1, 1, 0, 6'd0, 0, 6'd0);
        #2;
        chk("empty_gnt0", 32'(alloc_gnt0_o), 32'd0);
        chk("empty_gnt1", 32'(alloc_gnt1_o), 32'd0);
        tick();

        // One entry left: dual request gives lane 0 only.
        goto_count1();
        drive(0, 1, 1, 0, 6'd0, 0, 6'd0);
        #2;
        chk("one_dual_gnt0", 32'(alloc_gnt0_o), 32'd1);
        chk("one_dual_preg0", 32'(alloc_preg0_o), 32'd63);
        chk("one_dual_gnt1", 32'(alloc_gnt1_o), 32'd0);
        tick();
        // One entry left: lane 1 alone gets it.
        goto_count1();
        drive(0, 0, 1, 0, 6'd0, 0, 6'd0);
        #2;
        chk("one_l1_gnt1", 32'(alloc_gnt1_o), 32'd1);
        chk("one_l1_preg1", 32'(alloc_preg1_o), 32'd63);
        tick();

        // Frees into an empty list are not bypassed to grants.
        do_reset();
        alloc_pairs(16);
        drive(0, 1, 0, 1, 6'd5, 1, 6'd9);
        #2;
        chk("nobypass_gnt0", 32'(alloc_gnt0_o), 32'd0);
        tick();
        chk("after_free_count", 32'(count_o), 32'd2);
        drive(0, 1, 1, 0, 6'd0, 0, 6'd0);
        #2;
        chk("freed_preg0", 32'(alloc_preg0_o), 32'd5);
        chk("freed_preg1", 32'(alloc_preg1_o), 32'd9);
        tick();

        // Free into a full list overflows; with a same-cycle grant it fits.
        do_reset();
        drive(0, 0, 0, 1, 6'd7, 0, 6'd0);
        tick();
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'd32);
        drive(0, 1, 0, 0, 6'd0, 0, 6'd0);
        #2;
        chk("ovf_next_preg0", 32'(alloc_preg0_o), 32'd32);
        tick();
        do_reset();
        drive(0, 1, 0, 1, 6'd7, 0, 6'd0);
        tick();
        chk("full_swap_count", 32'(count_o), 32'd32);
        chk("full_swap_ovf", 32'(overflow_o), 32'd0);

        // Wrap: allocate all, free three, allocate three, free two.
        do_reset();
        alloc_pairs(16);
        drive(0, 0, 0, 1, 6'd40, 1, 6'd41); tick();
        drive(0, 0, 0, 1, 6'd42, 0, 6'd0);  tick();
        drive(0, 1, 1, 0, 6'd0, 0, 6'd0);  tick();
        drive(0, 0, 1, 0, 6'd0, 0, 6'd0);  tick();
        drive(0, 0, 0, 1, 6'd50, 1, 6'd51); tick();
        alloc_pairs(1);
        // Reset in the middle of traffic.
        drive(1, 1, 1, 1, 6'd3, 1, 6'd4);
        #2;
        chk("rst_gnt0", 32'(alloc_gnt0_o), 32'd0);
        chk("rst_gnt1", 32'(alloc_gnt1_o), 32'd0);
        tick();
        chk("midrst_count", 32'(count_o), 32'd32);
        chk("midrst_ovf", 32'(overflow_o), 32'd0);
        drive(0, 1, 0, 0, 6'd0, 0, 6'd0);
        #2;
        chk("midrst_preg0", 32'(alloc_preg0_o), 32'd32);
        tick();

        // Randomized traffic with alternating allocate/free bias.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 150) % 3)
                0:       begin preq = 80; pfree = 20; end
                1:       begin preq = 20; pfree = 80; end
                default: begin preq = 50; pfree = 50; end
            endcase
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < preq, $urandom_range(0, 99) < preq,
                  $urandom_range(0, 99) < pfree, 6'($urandom_range(0, 63)),
                  $urandom_range(0, 99) < pfree, 6'($urandom_range(0, 63)));
            tick();
        end

        drive(0, 0, 0, 0, 6'd0, 0, 6'd0);
        tick();
        @(negedge clk_i); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
